fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
- Sequences the instruction-memory fetch path: owns the PC, issues word reads to the synchronous instruction memory, and buffers returned instructions with their PC.
- Hands instructions to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute and discards wrong-path instructions.
- Sits between the instruction memory and the decode stage of the RISC-V core.

Parameters:
- XLEN, 32, address/data width.
- RESET_PC, 32'h00000000, PC loaded on reset.
- BUF_DEPTH, 2, instruction buffer entries (power of two, >=2).

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- fetch_en  input  1  permits new fetch requests.
- redirect_valid  input  1  single-cycle redirect strobe from execute.
- redirect_pc  input  XLEN  redirect target.
- imem_req  output  1  read request to instruction memory.
- imem_addr  output  XLEN  byte address of the request (word-aligned).
- imem_rdata  input  XLEN  read data; valid exactly one cycle after imem_req.
- inst_valid  output  1  buffer head holds a valid instruction.
- inst_ready  input  1  decode accepts head this cycle.
- inst_out  output  XLEN  head instruction.
- inst_pc  output  XLEN  PC of head instruction.
- misalign_err  output  1  sticky flag: a redirect target was not word-aligned.

Behaviour:
- Reset: pc=RESET_PC, state=IDLE, buffer empty, inflight=0.
  - Outputs during and after reset: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_out=0, inst_pc=0, misalign_err=0.
  - Reset asserted mid-operation cancels everything, including an in-flight response; no stale write follows.
- FSM states and transitions:
  - IDLE -> FETCH when fetch_en=1.
  - FETCH -> IDLE when fetch_en=0. Already-issued responses are still captured.
  - any -> HALT on a misaligned redirect (redirect_pc[1:0]!=0).
  - HALT is left only by reset.
- Issue rule (FETCH only): imem_req = (count + inflight - pop) < BUF_DEPTH, where pop = inst_valid & inst_ready.
  - imem_addr = pc.
  - On issue: pc <= pc+4, inflight <= 1; otherwise inflight <= 0.
  - pc wraps modulo 2^XLEN (32'hFFFFFFFC -> 0).
- Response: in the cycle after an issue, imem_rdata is written to the buffer tail together with the request PC, unless killed.
- Latency: request in cycle N, data in N+1, inst_valid=1 in N+2.
  - Sustained throughput is 1 instruction/cycle with inst_ready held high.
- Handshake:
  - inst_out and inst_pc hold stable while inst_valid=1 and inst_ready=0.
  - Pop and push in the same cycle is legal when the buffer is full.
  - The issue rule guarantees the buffer never overflows; an overflow is an assertion failure.
- Redirect has priority over issue, push and pop in the same cycle:
  - Buffer flushed, so inst_valid=0 next cycle.
  - A response arriving next cycle is killed: kill flag set when inflight=1.
  - pc <= redirect_pc.
  - No request is issued in the redirect cycle; the first request at redirect_pc comes the following cycle (if in FETCH).
  - A redirect in IDLE updates pc and flushes the buffer.
  - Misaligned redirect: misalign_err <= 1, buffer flushed, go to HALT. HALT issues no requests, keeps inst_valid=0, and holds pc.
- Empty buffer: inst_valid=0; inst_out and inst_pc hold their last values (0 after reset).

Decomposition:
- Package fetch_pkg:
  - state enum fetch_state_t {IDLE, FETCH, HALT};
  - XLEN default;
  - INSTR_BYTES=4;
  - NOP_INSTR=32'h00000013;
  - struct fetch_entry_t {inst, pc}.
- Sub-module fetch_buf: BUF_DEPTH FIFO of fetch_entry_t with push, pop, flush, count, and head outputs.
- fetch_ctrl holds the FSM, PC, inflight and kill logic.

Test Plan:
- Memory model returns aaaaaaaa/bbbbbbbb/cccccccc/dddddddd at 0x0/0x4/0x8/0xC; reset released, fetch_en=1, inst_ready=1 -> imem_addr 0,4,8,C on consecutive cycles; inst_out aaaaaaaa..dddddddd with inst_pc 0..C on consecutive cycles; first inst_valid 2 cycles after first imem_req.
- inst_ready=0 for 5 cycles after first inst_valid -> at most 2 entries buffered; imem_req drops; inst_out stays aaaaaaaa, inst_pc=0; after release, stream resumes with no loss or duplication.
- Redirect to 0x8 while inst_pc=0x0 is at head with one request in flight -> buffer flushed; in-flight data dropped; next delivered instructions are cccccccc (pc 0x8), then dddddddd (pc 0xC).
- Redirect to 0x6 -> misalign_err=1 next cycle; imem_req=0 and inst_valid=0 thereafter until reset; after reset, misalign_err=0 and fetch restarts at 0x0.
- fetch_en toggled low for 3 cycles mid-stream -> no new requests; the pending response is still delivered; resumes at the next sequential PC.
- RESET_PC=32'hFFFFFFFC -> addresses FFFFFFFC then 00000000; reset asserted with a request in flight -> all outputs return to their reset values next cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HALT
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Small FIFO holding fetched instructions with their PCs; the head output
// keeps showing the most recently visible entry once the FIFO drains.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  fetch_entry_t             pushData_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output fetch_entry_t             head_o
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem_q [DEPTH];
  fetch_entry_t   last_q;
  logic [AW-1:0]  wrPtr_q;
  logic [AW-1:0]  rdPtr_q;
  logic [AW:0]    count_q;
  logic           doPush;
  logic           doPop;

  assign doPush = push_i && !flush_i;
  assign doPop  = pop_i && !flush_i && (count_q != '0);

  // Entry storage; slots are only observed when counted valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (!reset && doPush) begin
      mem_q[wrPtr_q] <= pushData_i;
    end
  end

  // Pointer and occupancy bookkeeping, plus a copy of the last head shown to decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      last_q  <= '0;
    end else begin
      if (count_q != '0) begin
        last_q <= mem_q[rdPtr_q];
      end
      if (flush_i) begin
        wrPtr_q <= '0;
        rdPtr_q <= '0;
        count_q <= '0;
      end else begin
        if (doPush) begin
          wrPtr_q <= wrPtr_q + 1'b1;
        end
        if (doPop) begin
          rdPtr_q <= rdPtr_q + 1'b1;
        end
        case ({doPush, doPop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  assign count_o = count_q;
  assign head_o  = (count_q != '0) ? mem_q[rdPtr_q] : last_q;

  // The issue throttle upstream must never let a push land on a full FIFO.
  assert property (@(posedge clk) disable iff (reset)
    !(doPush && !doPop && (count_q == (AW+1)'(DEPTH))));

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, throttles instruction-memory reads against
// buffer space, handles redirects and hands instructions to decode.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              XLEN      = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_en,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_out,
  output logic [XLEN-1:0] inst_pc,
  output logic            misalign_err
);

  localparam int CW = $clog2(BUF_DEPTH);
  localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

  fetch_state_t    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] respPc_q;
  logic            inflight_q;
  logic            killResp_q;
  logic            misalign_q;

  logic [CW:0]     bufCount;
  fetch_entry_t    bufHead;
  fetch_entry_t    pushEntry;
  logic [CW+1:0]   occupancy;
  logic            popInst;
  logic            pushResp;
  logic            issueReq;
  logic            misalignedRedirect;

  // Space left after counting the response still on its way back and this cycle's pop.
  assign popInst   = inst_valid && inst_ready;
  assign occupancy = {1'b0, bufCount} + (CW+2)'(inflight_q) - (CW+2)'(popInst);

  assign misalignedRedirect = redirect_valid && (redirect_pc[1:0] != 2'b00);

  // A redirect cycle never issues, so the first request at the new target follows it.
  assign issueReq = !reset && !redirect_valid && fetch_en && (state_q == FETCH) &&
                    (occupancy < (CW+2)'(BUF_DEPTH));

  // Responses are dropped if a redirect flushes this cycle or the previous one.
  assign pushResp  = inflight_q && !killResp_q && !redirect_valid;
  assign pushEntry = '{inst: imem_rdata, pc: respPc_q};

  fetch_buf #(
    .DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .push_i     (pushResp),
    .pushData_i (pushEntry),
    .pop_i      (popInst),
    .flush_i    (redirect_valid),
    .count_o    (bufCount),
    .head_o     (bufHead)
  );

  // Fetch FSM, PC sequencing, in-flight tracking and the sticky misalignment flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      respPc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      killResp_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      inflight_q <= issueReq;
      killResp_q <= redirect_valid && inflight_q;
      if (issueReq) begin
        pc_q     <= pc_q + STEP;
        respPc_q <= pc_q;
      end
      if (misalignedRedirect) begin
        state_q    <= HALT;
        misalign_q <= 1'b1;
      end else begin
        if (redirect_valid && (state_q != HALT)) begin
          pc_q <= redirect_pc;
        end
        case (state_q)
          IDLE:    if (fetch_en) state_q <= FETCH;
          FETCH:   if (!fetch_en) state_q <= IDLE;
          HALT:    state_q <= HALT;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign imem_req     = issueReq;
  assign imem_addr    = pc_q;
  assign inst_valid   = (bufCount != '0);
  assign inst_out     = bufHead.inst;
  assign inst_pc      = bufHead.pc;
  assign misalign_err = misalign_q;

endmodule
